// File: rtl/data_mem.sv
// rtl/data_mem.sv - SCC data-port memory responder with wait states; DMEM_ALIGN_CHECK_EN enables misalignment faults
// One 32-bit word access per request, completed by a single-cycle data_ready pulse.
module data_mem #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_out,
    input  logic        data_read,
    input  logic        data_write,
    output logic [31:0] data_in,
    output logic        data_ready,
    output logic        data_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam int         WORDS  = 1 << DEPTH_LOG2;

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  is_wr_q, is_wr_d;
    logic                  mis_q, mis_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  req;
    logic                  mis_in;
    logic                  enter_resp;
    logic [31:0]           mem [WORDS];

`ifdef DMEM_ALIGN_CHECK_EN
    logic unused_addr_bits;
    assign mis_in           = (data_addr[1:0] != 2'b00);
    assign unused_addr_bits = ^data_addr[31:DEPTH_LOG2+2];
    assign data_err         = (state_q == S_RESP) & err_q;
`else
    logic unused_addr_bits;
    assign mis_in           = 1'b0;
    assign unused_addr_bits = ^{data_addr[31:DEPTH_LOG2+2], data_addr[1:0], err_q};
    assign data_err         = 1'b0;
`endif

    assign req        = data_read | data_write;
    assign data_ready = (state_q == S_RESP);
    assign data_in    = rdata_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        is_wr_d = is_wr_q;
        mis_d   = mis_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    idx_d   = data_addr[DEPTH_LOG2+1:2];
                    wdata_d = data_out;
                    is_wr_d = data_write;
                    mis_d   = mis_in;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // The *_d request fields hold the access being completed on the edge into RESP,
    // whether it was latched cycles ago or is being latched right now (zero wait states).
    assign enter_resp = reset && (state_d == S_RESP) && (state_q != S_RESP);

    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (enter_resp) begin
            err_d = mis_d;
            if (!is_wr_d) begin
                rdata_d = mis_d ? 32'h0 : mem[idx_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enter_resp && is_wr_d && !mis_d) begin
            mem[idx_d] <= wdata_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wdata_q <= 32'h0;
            is_wr_q <= 1'b0;
            mis_q   <= 1'b0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            is_wr_q <= is_wr_d;
            mis_q   <= mis_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_data_mem.sv
// tb/tb_data_mem.sv - self-checking bench for data_mem (WAIT_STATES=1 and 3 instances)
module tb_data_mem;

    localparam int WS0 = 1;
    localparam int WS1 = 3;

    logic        clk = 1'b0;
    logic        rst_n [2];
    logic        rd    [2];
    logic        wr    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdat  [2];
    logic [31:0] din   [2];
    logic        rdy   [2];
    logic        err   [2];

    always #5 clk = ~clk;

    data_mem #(.DEPTH_LOG2(10), .WAIT_STATES(WS0)) u_dut0 (
        .clk(clk), .reset(rst_n[0]), .data_addr(addr[0]), .data_out(wdat[0]),
        .data_read(rd[0]), .data_write(wr[0]), .data_in(din[0]),
        .data_ready(rdy[0]), .data_err(err[0])
    );

    data_mem #(.DEPTH_LOG2(10), .WAIT_STATES(WS1)) u_dut1 (
        .clk(clk), .reset(rst_n[1]), .data_addr(addr[1]), .data_out(wdat[1]),
        .data_read(rd[1]), .data_write(wr[1]), .data_in(din[1]),
        .data_ready(rdy[1]), .data_err(err[1])
    );

    typedef struct {
        bit          w;
        bit          r;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_din;
        bit          exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] din;
        bit          err;
    } exp_t;

    vec_t        vecs [$];
    exp_t        sbq  [$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] last_rd;

    function automatic int ws_of(input int d);
        return (d == 0) ? WS0 : WS1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input int d, input vec_t v, input bit push);
        wr[d]   = v.w;
        rd[d]   = v.r;
        addr[d] = v.a;
        wdat[d] = v.wd;
        if (push) sbq.push_back('{v.exp_din, v.exp_err});
    endtask

    task automatic finish_acc(input int d, input bit drop, input string name);
        int   cyc;
        exp_t e;
        cyc = 0;
        while (cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (drop && cyc == 1) begin
                rd[d] = 1'b0;
                wr[d] = 1'b0;
            end
            if (rdy[d]) break;
        end
        if (!rdy[d]) begin
            total++;
            bad++;
            $display("FAIL %s_ready timeout actual=none expected=pulse", name);
            if (sbq.size() > 0) e = sbq.pop_front();
        end else begin
            chk({name, "_lat"}, 32'(cyc), 32'(ws_of(d) + 1));
            e = sbq.pop_front();
            chk({name, "_din"}, din[d], e.din);
            chk({name, "_err"}, {31'h0, err[d]}, {31'h0, e.err});
            @(posedge clk); #1;
            chk({name, "_pulse"}, {31'h0, rdy[d]}, 32'h0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; rd[d] = 1'b0; wr[d] = 1'b0;
            addr[d] = 32'h0; wdat[d] = 32'h0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("idle%0d_rdy", d), {31'h0, rdy[d]}, 32'h0);
                chk($sformatf("idle%0d_err", d), {31'h0, err[d]}, 32'h0);
                chk($sformatf("idle%0d_din", d), din[d], 32'h0);
            end
        end

        vecs.push_back('{1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h0000_1004, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h0000_0004, 32'h0,         32'hA5A5_A5A5, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h0000_0FFC, 32'h0BAD_F00D, 32'hA5A5_A5A5, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0,         32'h0BAD_F00D, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h0000_0030, 32'h3333_3333, 32'hDEAD_BEEF, 1'b0});
`ifdef DMEM_ALIGN_CHECK_EN
        vecs.push_back('{1'b1, 1'b0, 32'h0000_0031, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 32'h0000_0030, 32'h0,         32'h3333_3333, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h0000_0031, 32'h0,         32'h0000_0000, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 32'h0000_0030, 32'h0,         32'h3333_3333, 1'b0});
`else
        vecs.push_back('{1'b0, 1'b1, 32'h0000_0030, 32'h0,         32'h3333_3333, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h0000_0033, 32'h0,         32'h3333_3333, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h0000_0031, 32'hFFFF_FFFE, 32'h3333_3333, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h0000_0030, 32'h0,         32'hFFFF_FFFE, 1'b0});
`endif

        last_rd = 32'h0;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(0, vecs[i], 1'b1);
            finish_acc(0, 1'b1, $sformatf("vec%0d", i));
            if (vecs[i].r && !vecs[i].w) last_rd = vecs[i].exp_din;
        end

        // Both strobes held through RESP: the write must win, then a read issued
        // in the very next IDLE cycle must see it.
        @(negedge clk);
        drive(0, '{1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, last_rd, 1'b0}, 1'b1);
        finish_acc(0, 1'b0, "b2b_wr");
        drive(0, '{1'b0, 1'b1, 32'h0000_0020, 32'h0, 32'h1234_5678, 1'b0}, 1'b1);
        finish_acc(0, 1'b1, "b2b_rd");

        @(negedge clk);
        drive(1, '{1'b1, 1'b0, 32'h0000_0030, 32'h2222_2222, 32'h0, 1'b0}, 1'b1);
        finish_acc(1, 1'b1, "ws3_wr");
        @(negedge clk);
        drive(1, '{1'b0, 1'b1, 32'h0000_0030, 32'h0, 32'h2222_2222, 1'b0}, 1'b1);
        finish_acc(1, 1'b1, "ws3_rd");

        @(negedge clk);
        drive(1, '{1'b1, 1'b0, 32'h0000_0030, 32'h1111_1111, 32'h0, 1'b0}, 1'b0);
        @(posedge clk); #1;
        rd[1] = 1'b0;
        wr[1] = 1'b0;
        @(posedge clk); #1;
        rst_n[1] = 1'b0;
        #1;
        chk("abort_rdy_c2", {31'h0, rdy[1]}, 32'h0);
        chk("abort_din_rst", din[1], 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n[1] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("abort_rdy%0d", c), {31'h0, rdy[1]}, 32'h0);
        end
        @(negedge clk);
        drive(1, '{1'b0, 1'b1, 32'h0000_0030, 32'h0, 32'h2222_2222, 1'b0}, 1'b1);
        finish_acc(1, 1'b1, "abort_rd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem.md
# data_mem

Data-memory responder for the SCC core: the memory-side end of the core's data port. It accepts the core's read and write strobes, inserts a parameterized number of wait states, then performs one 32-bit word access on an internal RAM. It signals completion with a one-cycle `data_ready` pulse and returns read data on `data_in`. It sits between the SCC top level and the system's data storage, and stalls the core until each access completes.

## Interface
Parameters:
- `DEPTH_LOG2`, default 10: log2 of RAM depth in 32-bit words (1024 words).
- `WAIT_STATES`, default 1: wait cycles inserted before each access completes. Legal range is 0..15.

Ports:
- `clk`  input  1  main clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `data_addr`  input  32  byte address from the core.
- `data_out`  input  32  write data from the core.
- `data_read`  input  1  read request strobe.
- `data_write`  input  1  write request strobe.
- `data_in`  output  32  read data to the core.
- `data_ready`  output  1  access complete; high for exactly one cycle.
- `data_err`  output  1  access faulted; valid only while `data_ready` is high.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - Strobes are sampled only in this state.
  - If `data_write` or `data_read` is high, the block latches `data_addr`, `data_out` and the operation type.
  - It then loads the wait counter with `WAIT_STATES`.
  - Next state is WAIT, or RESP if `WAIT_STATES` is 0.
- **WAIT**
  - The counter decrements each cycle.
  - When the counter reaches 1, the next state is RESP.
  - Strobe changes during WAIT are ignored; all request fields are already latched.
- **Entry to RESP**, on the edge entering RESP:
  - A write commits `RAM[addr[DEPTH_LOG2+1:2]] <= wdata`.
  - A read registers `data_in <= RAM[index]`.
- **RESP**
  - `data_ready` is 1 for this single cycle.
  - Next state is IDLE unconditionally.
- **Back-to-back access:** a strobe still high in the IDLE cycle after RESP starts a new access. The core must drop its strobes after seeing `data_ready` unless it intends another access.
- **Simultaneous `data_read` and `data_write` in IDLE:** the write wins and the read is ignored.
- **Address handling**
  - Word index is `data_addr[DEPTH_LOG2+1:2]`.
  - Bits above `DEPTH_LOG2+1` are ignored, so addresses alias modulo `4 << DEPTH_LOG2` bytes.
- **`data_in` hold behaviour:** holds the last read value. Writes do not change `data_in`.
- **RAM contents:** not reset; they are undefined after power-up.

## Timing
- Reset values:
  - State is IDLE.
  - `data_in` = 0, `data_ready` = 0, `data_err` = 0.
  - Wait counter = 0.
  - The latched request registers are cleared.
- Latency: request present in IDLE cycle 0 → `data_ready` high in cycle `WAIT_STATES`+1.
  - `WAIT_STATES`=0 → `data_ready` in cycle 1.
  - `WAIT_STATES`=3 → `data_ready` in cycle 4.
- Throughput: one access per `WAIT_STATES`+2 cycles with back-to-back strobes.
- Read data: `data_in` is valid in the RESP cycle and stable until the next read's RESP.
- Write visibility: a read issued in the IDLE cycle immediately after a write's RESP returns the new value.
- Reset mid-operation (asserted in WAIT or RESP):
  - The block aborts immediately and returns to IDLE.
  - A pending write not yet committed is dropped.
  - No `data_ready` pulse is produced for the aborted access.

## Configuration
Macro: `DMEM_ALIGN_CHECK_EN`.
- **Defined:** a request with `data_addr[1:0] != 0` is misaligned.
  - It goes through the same WAIT sequence.
  - In RESP it asserts `data_ready` = 1 and `data_err` = 1.
  - A misaligned write leaves the RAM unmodified.
  - A misaligned read sets `data_in` = 0.
- **Undefined:**
  - `data_addr[1:0]` is ignored; the access uses the word index.
  - `data_err` is tied to 0.

## Test plan
- Reset then idle: drive `reset`=0, release it, hold strobes low for 10 cycles → `data_ready`=0, `data_err`=0 and `data_in`=0 throughout.
- Write/read round trip, `WAIT_STATES`=1:
  - Write 0xDEADBEEF to 0x10 → `data_ready` in cycle 2.
  - Read 0x10 → `data_in`=0xDEADBEEF with `data_ready` in cycle 2.
- Back-to-back and priority:
  - Assert both strobes with addr 0x20 and data 0x12345678, hold strobes high across RESP → write wins.
  - The following access reads 0x20 → 0x12345678.
- Aliasing, `DEPTH_LOG2`=10: write 0xA5A5A5A5 to 0x1004 → a read of 0x0004 returns 0xA5A5A5A5.
- Reset mid-write, `WAIT_STATES`=3:
  - Write 0x11111111 to 0x30.
  - Assert reset in cycle 2 → no `data_ready` pulse.
  - A subsequent read of 0x30 returns the prior value.
- With `DMEM_ALIGN_CHECK_EN`: write to 0x31 → `data_ready`=1 and `data_err`=1, the word at 0x30 is unchanged, and a read of 0x31 returns `data_in`=0 with `data_err`=1.
